charlie7x5_scan: RTL
====================

# charlie7x5_scan

Charlieplexing scanner for the 7-pin / 35-LED matrix. It holds a 7×5 framebuffer written over a Wishbone classic slave port. It time-multiplexes the framebuffer onto `charlie7x5_oe` / `charlie7x5_o`, which feed the board's tristate SB_IO cells directly. It adds PWM brightness and anti-ghosting blanking, and optionally double-buffers frames.

## Interface
- `PHASE_BITS`, default 12: log2 of clock ticks per anode phase. 4096 ticks gives ≈1.67 kHz frame rate at 48 MHz. Must be ≥ 6.
- `BLANK_TICKS`, default 32: ticks at the start of each phase with all pins released. Must be < 2^(PHASE_BITS-4).
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `wb_cyc_i`, in, 1: Wishbone cycle.
- `wb_stb_i`, in, 1: Wishbone strobe.
- `wb_we_i`, in, 1: write enable.
- `wb_adr_i`, in, 3: address; 0–6 = row (anode) 0–6, 7 = control.
- `wb_dat_i`, in, 8: write data.
- `wb_dat_o`, out, 8: read data.
- `wb_ack_o`, out, 1: single-cycle acknowledge.
- `charlie7x5_oe`, out, 7: per-pin output enable (1 = driven).
- `charlie7x5_o`, out, 7: per-pin output level.

## Operation
- Framebuffer: 7 rows × 5 bits. Row p bit k lights the LED with anode pin p and cathode pin (p+1+k) mod 7.
- Control register (addr 7):
  - bit7 EN: display enable.
  - bit6 SWAP: swap request; used only in double-buffer builds.
  - bits3:0 LEVEL: brightness.
  - Other bits read 0.
- Scan counter: `phase` runs 0..6 and `tick` is PHASE_BITS wide. `tick` increments every clock. When `tick` wraps, `phase` advances, and 6 wraps to 0.
- At tick 0 of each phase, the displayed row[phase] is latched into an internal row register. Writes become visible at the next phase entry, never mid-phase.
- PWM slot = `tick[PHASE_BITS-1:PHASE_BITS-4]`.
- Drive is active when EN=1, tick ≥ BLANK_TICKS, and slot ≤ LEVEL. LEVEL=15 gives full duty minus blanking; LEVEL=0 gives 1/16.
- While drive is active:
  - Anode pin `phase`: oe=1, o=1.
  - Cathode pin (phase+1+k) mod 7 with latched bit k = 1: oe=1, o=0.
  - All other pins: oe=0, o=0.
- While drive is inactive, all pins have oe=0 and o=0.
- Row reads return {3'b0, row[4:0]}. Row writes store `wb_dat_i[4:0]`.
- Wishbone slave:
  - `wb_ack_o` ← `wb_cyc_i & wb_stb_i & !wb_ack_o`, registered, so each access acks exactly one cycle after the strobe.
  - The write takes effect on the same edge that raises ack.
  - `wb_dat_o` is valid while ack is high.
  - Back-to-back strobes ack every other cycle.

## Timing
- Reset values:
  - All framebuffer rows 0, control 0x00 (disabled).
  - `phase`=0, `tick`=0.
  - `charlie7x5_oe`=0, `charlie7x5_o`=0, `wb_ack_o`=0, `wb_dat_o`=0.
- Pin outputs are registered. They reflect the scan counter state with one clock of latency.
- A phase change always passes through ≥ BLANK_TICKS cycles of all-released pins. No two pins are ever driven high simultaneously.
- Reset mid-phase or mid-access: outputs read 0 on the cycle after `rst`. Scanning restarts at phase 0, tick 0. Any pending ack is dropped.
- A control write with EN=0 releases all pins on the next cycle, since the drive term is evaluated every tick.
- A row write to the row currently being displayed does not alter that phase's output.

## Configuration
- `CHARLIE7X5_DOUBLE_BUFFER_EN` defined:
  - Row writes and reads target a back buffer.
  - Writing control with bit6=1 sets a swap-pending flag, readable as bit6.
  - On the last tick of phase 6, if pending, the back buffer is copied to the front buffer and pending clears.
  - Scanning reads only the front buffer. Reset clears both buffers and pending.
- Not defined:
  - A single buffer is used; row writes go to it directly.
  - bit6 is ignored on write and reads 0.

## Test plan
- Reset, then write row 0 = 0x01 and control = 0x8F. In phase 0 after blanking, expect oe=7'b0000011 and o=7'b0000001. During ticks 0..31, expect oe=0.
- Write row 6 = 0x1F at LEVEL 15. In phase 6, expect oe=7'b1111111 except pin 5 (o[6]=1, pins 0–4 low, pin 5 released). Ghost check: no cycle with two o=1 pins while oe=1.
- Control = 0x83 (LEVEL 3). Expect drive only in slots 0–3: per-phase on-cycles = 4·256 − 32 = 992 at PHASE_BITS=12.
- Control write 0x00 mid-phase → oe=0 from the next cycle. Write 0x80 → drive resumes at the following eligible slot.
- Wishbone: write addr 2 = 0xFF, read addr 2 → 0x1F. Ack is exactly one cycle wide, one cycle after stb. Read addr 7 after writing 0xCF → 0x8F (single-buffer) or 0xCF until frame end (double-buffer).
- Double-buffer build: write row 0 = 0x01 without SWAP. The display stays dark. Write control 0xC8. After the next phase-6 wrap, row 0 lights and bit6 reads 0.

Source files
------------

// File: rtl/charlie7x5_scan_if.sv
// -----------------------------------------------------------------------------
// charlie7x5_scan_if
//
// Wishbone classic bus bundle for the charlie7x5_scan register port.
//
// Signals (directions as seen from the slave):
//   wb_cyc_i   in   1  bus cycle
//   wb_stb_i   in   1  strobe
//   wb_we_i    in   1  write enable
//   wb_adr_i   in   3  0..6 = framebuffer row, 7 = control
//   wb_dat_i   in   8  write data
//   wb_dat_o   out  8  read data, valid while wb_ack_o is high
//   wb_ack_o   out  1  single-cycle acknowledge
// -----------------------------------------------------------------------------
interface charlie7x5_scan_if;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/charlie7x5_scan.sv
// -----------------------------------------------------------------------------
// charlie7x5_scan
//
// Charlieplexing scanner for a 7-pin / 35-LED matrix. A 7x5 framebuffer is
// written over a Wishbone classic slave port and time-multiplexed onto the
// tristate pin pair charlie7x5_oe / charlie7x5_o, with PWM brightness and a
// blanking window at the start of every anode phase to suppress ghosting.
//
// Row p bit k lights the LED with anode pin p and cathode pin (p+1+k) mod 7.
//
// Parameters:
//   PHASE_BITS   log2 of clock ticks per anode phase (>= 6)
//   BLANK_TICKS  all-released ticks at the start of each phase
//                (< 2**(PHASE_BITS-4))
//
// Ports:
//   clk            in   1  single clock domain
//   rst            in   1  synchronous, active-high reset
//   wb             slave  Wishbone classic bus (charlie7x5_scan_if)
//   charlie7x5_oe  out  7  per-pin output enable (1 = driven)
//   charlie7x5_o   out  7  per-pin output level
//
// Register map:
//   0..6  row n      read {3'b0, row[4:0]}, write stores dat[4:0]
//   7     control    bit7 EN, bit6 SWAP (double-buffer only), bits3:0 LEVEL
//
// Build option:
//   CHARLIE7X5_DOUBLE_BUFFER_EN  when defined, the bus targets a back buffer
//   that is copied to the displayed buffer on the last tick of phase 6 after
//   a SWAP request. When undefined, a single buffer is used and SWAP reads 0.
// -----------------------------------------------------------------------------
module charlie7x5_scan #(
  parameter int PHASE_BITS  = 12,
  parameter int BLANK_TICKS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  charlie7x5_scan_if.slave      wb,
  output logic [6:0]            charlie7x5_oe,
  output logic [6:0]            charlie7x5_o
);

  localparam logic [2:0] CTRL_ADDR  = 3'd7;
  localparam logic [2:0] LAST_PHASE = 3'd6;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PHASE_BITS-1:0] tick_q, tick_d;
  logic [2:0]            phase_q, phase_d;
  logic [4:0]            row_q, row_d;        // row latched at phase entry
  logic [4:0]            front_q [7];         // buffer the scanner reads
  logic                  en_q;
  logic [3:0]            level_q;
  logic [6:0]            oe_q, oe_d;
  logic [6:0]            o_q, o_d;
  logic                  ack_q;
  logic [7:0]            dat_q, rd_data_d;

`ifdef CHARLIE7X5_DOUBLE_BUFFER_EN
  logic [4:0]            back_q [7];          // buffer the bus sees
  logic                  pend_q;              // swap requested, not yet done
`endif

  // ---------------------------------------------------------------------------
  // Scan counter
  // ---------------------------------------------------------------------------
  logic tick_wrap;
  logic phase_start;
  logic [3:0] slot;
  logic drive;

  assign tick_wrap   = &tick_q;
  assign phase_start = (tick_q == '0);
  assign tick_d      = tick_q + 1'b1;
  assign phase_d     = !tick_wrap             ? phase_q :
                       (phase_q == LAST_PHASE) ? 3'd0   : phase_q + 3'd1;

  // The row register is refreshed only on tick 0, so bus writes never change
  // a phase that is already being displayed. On tick 0 itself the fresh
  // buffer value is used directly.
  assign row_d = phase_start ? front_q[phase_q] : row_q;

  // PWM: the phase is cut into 16 slots and slots 0..LEVEL are lit.
  assign slot  = tick_q[PHASE_BITS-1:PHASE_BITS-4];
  assign drive = en_q
              && (tick_q >= PHASE_BITS'(BLANK_TICKS))
              && (slot <= level_q);

  // Rotate a 7-bit pattern left by n (n <= 6) around the pin ring.
  function automatic logic [6:0] rotl7(input logic [6:0] v, input logic [2:0] n);
    logic [13:0] w;
    w = {v, v} << n;
    return w[13:7];
  endfunction

  // Pattern relative to the anode: bit0 = anode, bits 1..5 = cathodes k=0..4,
  // bit6 = the one pin that never pairs with this anode. Rotating by phase
  // maps it onto the physical pins. Only the anode is ever driven high, so two
  // high pins cannot occur.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    oe_d = '0;
    o_d  = '0;
    if (drive) begin
      oe_d = rotl7({1'b0, row_d, 1'b1}, phase_q);
      o_d  = rotl7(7'b000_0001, phase_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic access;
  logic wr_row;
  logic wr_ctrl;
  logic swap_bit;

  // Ack is registered and suppressed while already high, so each strobe gets
  // exactly one ack one cycle later and held strobes ack every other cycle.
  assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_row  = access & wb.wb_we_i & (wb.wb_adr_i != CTRL_ADDR);
  assign wr_ctrl = access & wb.wb_we_i & (wb.wb_adr_i == CTRL_ADDR);

`ifdef CHARLIE7X5_DOUBLE_BUFFER_EN
  logic swap_now;
  assign swap_bit = pend_q;
  // Swap lands on the last tick of phase 6 so the new frame starts cleanly
  // at phase 0 tick 0.
  assign swap_now = tick_wrap & (phase_q == LAST_PHASE) & pend_q;
`else
  assign swap_bit = 1'b0;
`endif

  always_comb begin
    rd_data_d = 8'h00;
    if (access && !wb.wb_we_i) begin
      if (wb.wb_adr_i == CTRL_ADDR) begin
        rd_data_d = {en_q, swap_bit, 2'b00, level_q};
      end else begin
`ifdef CHARLIE7X5_DOUBLE_BUFFER_EN
        rd_data_d = {3'b000, back_q[wb.wb_adr_i]};
`else
        rd_data_d = {3'b000, front_q[wb.wb_adr_i]};
`endif
      end
    end
  end

  // Write-data bits that carry no register meaning.
  logic unused_dat;
`ifdef CHARLIE7X5_DOUBLE_BUFFER_EN
  assign unused_dat = &{1'b0, wb.wb_dat_i[5:4]};
`else
  assign unused_dat = &{1'b0, wb.wb_dat_i[6:4]};
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      tick_q  <= '0;
      phase_q <= '0;
      row_q   <= '0;
      en_q    <= 1'b0;
      level_q <= '0;
      oe_q    <= '0;
      o_q     <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      // NOTE: the framebuffer is a small flop array whose reset contents are
      // visible on the bus, so it is reset explicitly; a RAM-style buffer
      // would normally be left unreset.
      for (int i = 0; i < 7; i++) begin
        front_q[i] <= '0;
      end
`ifdef CHARLIE7X5_DOUBLE_BUFFER_EN
      for (int i = 0; i < 7; i++) begin
        back_q[i] <= '0;
      end
      pend_q <= 1'b0;
`endif
    end else begin
      tick_q  <= tick_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      oe_q    <= oe_d;
      o_q     <= o_d;
      ack_q   <= access;
      dat_q   <= rd_data_d;

      if (wr_ctrl) begin
        en_q    <= wb.wb_dat_i[7];
        level_q <= wb.wb_dat_i[3:0];
      end

`ifdef CHARLIE7X5_DOUBLE_BUFFER_EN
      if (swap_now) begin
        for (int i = 0; i < 7; i++) begin
          front_q[i] <= back_q[i];
        end
        pend_q <= 1'b0;
      end
      // A request landing on the swap edge itself stays pending.
      if (wr_ctrl && wb.wb_dat_i[6]) begin
        pend_q <= 1'b1;
      end
      if (wr_row) begin
        back_q[wb.wb_adr_i] <= wb.wb_dat_i[4:0];
      end
`else
      if (wr_row) begin
        front_q[wb.wb_adr_i] <= wb.wb_dat_i[4:0];
      end
`endif
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign charlie7x5_oe = oe_q;
  assign charlie7x5_o  = o_q;

endmodule
